// File: rtl/stream_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and a width helper.
package stream_pkg;

  localparam logic [1:0] MODE_SEL  = 2'd0;
  localparam logic [1:0] MODE_PRIO = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;

  // Ceiling log2, never less than 1 so a two-channel mux still gets a select bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter; in priority mode the search always starts at 0.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [1:0]    mode,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  logic [PW-1:0] base;

  assign base = (mode == MODE_PRIO) ? '0 : ptr;

  // Walk base, base+1, ... modulo N and take the first requester.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with external-select, fixed-priority or
// round-robin arbitration feeding a single registered output beat.
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0]  arb_grant;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any_grant;
  logic             can_load;
  logic             xfer;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // External select bypasses the arbiter; an out-of-range select grants nothing.
  always_comb begin
    grant     = arb_grant;
    grant_idx = arb_idx;
    any_grant = arb_any;
    if (mode == MODE_SEL) begin
      grant     = '0;
      grant_idx = sel;
      any_grant = 1'b0;
      if ((int'(sel) < N_CH) && in_valid[sel]) begin
        grant[sel] = 1'b1;
        any_grant  = 1'b1;
      end
    end
  end

  // rst_n gates the handshake so no producer sees ready while reset is held.
  assign can_load = ~out_valid | out_ready;
  assign in_ready = (can_load && rst_n) ? grant : '0;
  assign xfer     = can_load & rst_n & any_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_ch    <= grant_idx;
      if (mode[1])
        ptr <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's gate-level 4:1 mux: N_CH-input, DATA_W-wide stream multiplexer with valid/ready handshakes on every port.
- Selection by external select, fixed priority or round-robin. Output is registered.
- Sits between several producer streams and one shared consumer, for example a shared bus or serialiser.

Parameters:
- N_CH, 4, number of input channels (>=2).
- DATA_W, 8, payload width per channel.
- SEL_W, $clog2(N_CH), derived local parameter (not overridable); width of select and channel-ID fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  0 = external select, 1 = fixed priority (lowest index wins), 2/3 = round-robin.
- sel  in  SEL_W  channel select, used in mode 0 only.
- in_valid  in  N_CH  per-channel valid.
- in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  N_CH  per-channel ready; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered payload.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready is combinational and therefore all 0 while rst_n=0.
- can_load = ~out_valid | out_ready.
- Grant (combinational, one-hot, or none):
  - mode 0: channel sel, only if sel<N_CH and in_valid[sel]. sel>=N_CH grants nothing.
  - mode 1: lowest index i with in_valid[i].
  - mode 2/3: first i with in_valid[i], searching ptr, ptr+1, ... modulo N_CH (wraps past N_CH-1 to 0).
- in_ready[i] = can_load & grant[i]. A transfer on channel i happens when in_valid[i] & in_ready[i].
- On a transfer at edge k: out_data <= in_data[g], out_ch <= g, out_valid <= 1 at edge k. Latency is one cycle from accept to visible output.
- Drain with no new transfer (out_valid & out_ready): out_valid <= 0.
- Simultaneous drain and load: out_valid stays 1 and the new beat replaces the old one. Sustained throughput is 1 beat/cycle, no bubble.
- Stall (out_valid & ~out_ready): out_data and out_ch must hold stable; all in_ready=0.
- Round-robin pointer: on a transfer in mode 2/3 with grant g, ptr <= (g==N_CH-1) ? 0 : g+1. In modes 0/1 ptr holds.
- Changes to mode or sel take effect at the next arbitration only. A beat already in the output register is never altered.
- A producer may drop in_valid without a transfer; the block must not latch anything for that channel.
- No valid inputs: no grant, and out_valid drains to 0.
- Reset mid-stream: the held beat is discarded immediately and out_valid=0 asynchronously.

Decomposition:
- Shared package stream_pkg holds:
  - mode encodings MODE_SEL=2'd0, MODE_PRIO=2'd1, MODE_RR=2'd2;
  - a clog2 helper function.
- One sub-module, rr_arbiter (params N; inputs req, ptr, mode; outputs grant one-hot plus grant index and any_grant). It is purely combinational and reused by the mode-1 path, with ptr forced to 0.
- The top level holds the output register, the pointer and the handshake logic.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; in_ready=0 while reset is held.
- Mode 0, N_CH=4, DATA_W=8: in_valid=4'b1111, data 0x10/0x21/0x32/0x43, sel=2, out_ready=1 -> one cycle later out_data=0x32, out_ch=2, in_ready=4'b0100; sel=3 -> 0x43 next. sel range check with N_CH=3, sel=3: no grant, in_ready=0.
- Mode 1: in_valid=4'b1010 -> ch1 served every cycle while held; drop ch1 -> ch3 served.
- Mode 2, all four valid, out_ready=1 continuously -> out_ch sequence 0,1,2,3,0,1 (wrap), one beat per cycle, out_valid never drops.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_ch unchanged and in_ready=0 throughout; release -> next beat loads in the same cycle as the drain.
- Mode 2 sparse: ptr=3, in_valid=4'b0011 -> ch0 granted (wrap), then ch1, then ch0; in_valid=0 -> out_valid falls after the last drain.
